// File: rtl/gb_host_master.sv
// gb_host_master: bridges a valid/ready host command port onto the ghostbus,
// one transaction at a time (single outstanding request).
// Latency: write strobe at accept+1 and response at accept+2. Read strobe at
//          accept+1 and response at strobe+RD+1.
// Backpressure: cmd_ready is high only in IDLE. The response is held in RESP
//               until resp_ready is high at a clock edge.
//
// Ports
//   clk, rst_n           single clock (also the ghostbus clock); async active-low reset
//   cmd_valid/cmd_ready  host request handshake; cmd_we/cmd_addr/cmd_wdata are
//                        sampled on accept
//   resp_valid/ready     response handshake; resp_we echoes the command, and
//                        resp_rdata carries read data (0 for writes)
//   gb_addr/gb_wdata     ghostbus address/data, updated only on accept
//   gb_wen/gb_rstb       one-cycle write/read strobes, never asserted together
//   gb_rdata             ghostbus read data, sampled RD cycles after gb_rstb
//   txn_count            completed transactions, wraps modulo 2^16
module gb_host_master #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int RD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_we,
  output logic [DW-1:0] resp_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_rdata,
  output logic [15:0]   txn_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // The wait counter starts at RD-1, so RDWAIT lasts exactly RD cycles.
  // That includes RD=1, where the counter is already zero on entry.
  localparam logic [7:0] RD_M1 = 8'(RD - 1);

  logic [1:0]    state_q, state_d;
  logic          rdy_q,   rdy_d;
  logic          we_q,    we_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wen_q,   wen_d;
  logic          rstb_q,  rstb_d;
  logic [7:0]    cnt_q,   cnt_d;
  logic          rvld_q,  rvld_d;
  logic          rwe_q,   rwe_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [15:0]   txn_q,   txn_d;
  logic          accept;

  // rdy_q is a registered copy of (state == IDLE). It is low throughout
  // reset and rises on the first edge after release.
  assign accept = rdy_q & cmd_valid;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    rstb_d  = 1'b0;
    cnt_d   = cnt_q;
    rvld_d  = rvld_q;
    rwe_d   = rwe_q;
    rdata_d = rdata_q;
    txn_d   = txn_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_STROBE;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          // Strobes are registered, so they are set up on the accept edge
          // and are visible only during the STROBE cycle.
          wen_d   = cmd_we;
          rstb_d  = ~cmd_we;
        end
      end

      S_STROBE: begin
        if (we_q) begin
          state_d = S_RESP;
          rvld_d  = 1'b1;
          rwe_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = S_RDWAIT;
          cnt_d   = RD_M1;
        end
      end

      S_RDWAIT: begin
        if (cnt_q == 8'd0) begin
          // This is cycle strobe+RD, so gb_rdata is valid now.
          state_d = S_RESP;
          rvld_d  = 1'b1;
          rwe_d   = 1'b0;
          rdata_d = gb_rdata;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rvld_d  = 1'b0;
          txn_d   = txn_q + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      rstb_q  <= 1'b0;
      cnt_q   <= 8'd0;
      rvld_q  <= 1'b0;
      rwe_q   <= 1'b0;
      rdata_q <= '0;
      txn_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      rstb_q  <= rstb_d;
      cnt_q   <= cnt_d;
      rvld_q  <= rvld_d;
      rwe_q   <= rwe_d;
      rdata_q <= rdata_d;
      txn_q   <= txn_d;
    end
  end

  assign cmd_ready  = rdy_q;
  assign resp_valid = rvld_q;
  assign resp_we    = rwe_q;
  assign resp_rdata = rdata_q;
  assign gb_addr    = addr_q;
  assign gb_wdata   = wdata_q;
  assign gb_wen     = wen_q;
  assign gb_rstb    = rstb_q;
  assign txn_count  = txn_q;

endmodule

// File: tb/tb_gb_host_master.sv
module tb_gb_host_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cmd_valid, cmd_we, resp_ready, sel;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata, gb_rdata;

  // Two instances: u_a has RD=8 and u_b has RD=1. sel routes cmd_valid to
  // one of them and picks which instance's outputs are observed.
  logic        a_cmd_ready, a_resp_valid, a_resp_we, a_gb_wen, a_gb_rstb;
  logic [31:0] a_resp_rdata, a_gb_wdata;
  logic [23:0] a_gb_addr;
  logic [15:0] a_txn_count;
  logic        b_cmd_ready, b_resp_valid, b_resp_we, b_gb_wen, b_gb_rstb;
  logic [31:0] b_resp_rdata, b_gb_wdata;
  logic [23:0] b_gb_addr;
  logic [15:0] b_txn_count;

  gb_host_master #(.AW(24), .DW(32), .RD(8)) u_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_we(a_resp_we),
    .resp_rdata(a_resp_rdata), .gb_addr(a_gb_addr), .gb_wdata(a_gb_wdata),
    .gb_wen(a_gb_wen), .gb_rstb(a_gb_rstb), .gb_rdata(gb_rdata), .txn_count(a_txn_count));

  gb_host_master #(.AW(24), .DW(32), .RD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid & sel), .cmd_ready(b_cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_we(b_resp_we),
    .resp_rdata(b_resp_rdata), .gb_addr(b_gb_addr), .gb_wdata(b_gb_wdata),
    .gb_wen(b_gb_wen), .gb_rstb(b_gb_rstb), .gb_rdata(gb_rdata), .txn_count(b_txn_count));

  logic        o_cmd_ready, o_resp_valid, o_resp_we, o_gb_wen, o_gb_rstb;
  logic [31:0] o_resp_rdata, o_gb_wdata;
  logic [23:0] o_gb_addr;
  logic [15:0] o_txn_count;
  assign o_cmd_ready  = sel ? b_cmd_ready  : a_cmd_ready;
  assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign o_resp_we    = sel ? b_resp_we    : a_resp_we;
  assign o_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
  assign o_gb_addr    = sel ? b_gb_addr    : a_gb_addr;
  assign o_gb_wdata   = sel ? b_gb_wdata   : a_gb_wdata;
  assign o_gb_wen     = sel ? b_gb_wen     : a_gb_wen;
  assign o_gb_rstb    = sel ? b_gb_rstb    : a_gb_rstb;
  assign o_txn_count  = sel ? b_txn_count  : a_txn_count;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;     // value driven on gb_rdata in cycle strobe+RD
    int          dly;       // cycles that resp_ready is held low
    int          exp_lat;   // cycles from strobe until resp_valid is first high
    logic [31:0] exp_rdata;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_txn [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"},  64'(o_cmd_ready),  64'(0));
    chk({tag, "_resp_valid"}, 64'(o_resp_valid), 64'(0));
    chk({tag, "_resp_we"},    64'(o_resp_we),    64'(0));
    chk({tag, "_resp_rdata"}, 64'(o_resp_rdata), 64'(0));
    chk({tag, "_gb_addr"},    64'(o_gb_addr),    64'(0));
    chk({tag, "_gb_wdata"},   64'(o_gb_wdata),   64'(0));
    chk({tag, "_gb_wen"},     64'(o_gb_wen),     64'(0));
    chk({tag, "_gb_rstb"},    64'(o_gb_rstb),    64'(0));
    chk({tag, "_txn_count"},  64'(o_txn_count),  64'(0));
  endtask

  // Reference model: the expected latency and response data follow directly
  // from the transaction type and the configured read latency.
  function automatic vec_t mk(input logic we, input logic [23:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int dly, input int rd);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
    v.exp_lat   = we ? 1 : rd + 1;
    v.exp_rdata = we ? 32'd0 : rdata;
    return v;
  endfunction

  // Runs one transaction and checks every cycle from accept to handshake.
  // It is entered and left at a negedge.
  task automatic do_txn(input vec_t v);
    int n;
    cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_valid = 1'b1;
    n = 0;
    while (!o_cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("accept_timeout", 64'(0), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);  // strobe cycle; the command lines now carry garbage that must be ignored
    cmd_we = ~v.we; cmd_addr = 24'($urandom); cmd_wdata = $urandom;
    gb_rdata = ~v.rdata;
    chk("strobe_wen",  64'(o_gb_wen),  64'(v.we));
    chk("strobe_rstb", 64'(o_gb_rstb), 64'(!v.we));
    chk("strobe_addr", 64'(o_gb_addr), 64'(v.addr));
    chk("strobe_wdata", 64'(o_gb_wdata), 64'(v.wdata));
    chk("strobe_resp_valid", 64'(o_resp_valid), 64'(0));
    chk("strobe_cmd_ready", 64'(o_cmd_ready), 64'(0));
    for (int k = 1; k < v.exp_lat; k++) begin
      @(negedge clk);
      chk("wait_resp_valid", 64'(o_resp_valid), 64'(0));
      chk("wait_no_strobe", 64'({o_gb_wen, o_gb_rstb}), 64'(0));
      chk("wait_cmd_ready", 64'(o_cmd_ready), 64'(0));
      gb_rdata = (k == v.exp_lat - 1) ? v.rdata : ~v.rdata;
    end
    @(negedge clk);  // first response cycle
    gb_rdata = $urandom;
    for (int d = 0; d <= v.dly; d++) begin
      chk("resp_valid", 64'(o_resp_valid), 64'(1));
      chk("resp_we",    64'(o_resp_we),    64'(v.we));
      chk("resp_rdata", 64'(o_resp_rdata), 64'(v.exp_rdata));
      chk("resp_cmd_ready", 64'(o_cmd_ready), 64'(0));
      chk("resp_no_strobe", 64'({o_gb_wen, o_gb_rstb}), 64'(0));
      if (d == v.dly) begin resp_ready = 1'b1; cmd_valid = 1'b0; end
      else            begin resp_ready = 1'b0; cmd_valid = 1'b1; end
      @(negedge clk);
    end
    resp_ready = 1'b0;
    exp_txn[sel] = exp_txn[sel] + 16'd1;
    chk("post_resp_valid", 64'(o_resp_valid), 64'(0));
    chk("post_cmd_ready",  64'(o_cmd_ready),  64'(1));
    chk("post_txn_count",  64'(o_txn_count),  64'(exp_txn[sel]));
    chk("post_addr_stable", 64'(o_gb_addr),   64'(v.addr));
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{1'b1, 24'h000010, 32'h00000042, 32'hFFFFFFFF, 0,  1, 32'h0};
    tbl[1] = '{1'b0, 24'h000010, 32'h0,        32'hDEADBEEF, 0,  9, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 24'hFFFFFF, 32'h11111111, 32'h00000000, 20, 9, 32'h0};
    tbl[3] = '{1'b1, 24'h000000, 32'hFFFFFFFF, 32'hA5A5A5A5, 3,  1, 32'h0};
    tbl[4] = '{1'b0, 24'h800000, 32'h0,        32'h12345678, 1,  9, 32'h12345678};
    tbl[5] = '{1'b1, 24'h123456, 32'hCAFEF00D, 32'h0,        2,  1, 32'h0};

    rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; resp_ready = 1'b0; gb_rdata = '0;
    exp_txn[0] = 16'd0; exp_txn[1] = 16'd0;

    #3;
    chk_all_zero("rst_early");
    repeat (2) @(negedge clk);
    chk_all_zero("rst_held");
    rst_n = 1'b1;
    #1;
    chk("release_cmd_ready_before_edge", 64'(o_cmd_ready), 64'(0));
    @(negedge clk);
    chk("release_cmd_ready_after_edge", 64'(o_cmd_ready), 64'(1));

    // Directed table on the RD=8 instance
    for (int i = 0; i < 6; i++) do_txn(tbl[i]);

    // Randomised transactions on both latencies
    for (int i = 0; i < 40; i++) begin
      sel = (i >= 28);
      @(negedge clk);
      do_txn(mk(1'($urandom), 24'($urandom), $urandom, $urandom,
                $urandom_range(0, 4), sel ? 1 : 8));
    end

    // RD=1: the response appears at strobe+2
    sel = 1'b1;
    @(negedge clk);
    do_txn('{1'b0, 24'h0000AA, 32'h0, 32'h5A5A0001, 0, 2, 32'h5A5A0001});

    // Back-to-back writes with cmd_valid held high on RD=8
    sel = 1'b0;
    @(negedge clk);
    begin
      int wens, hss;
      logic prev_wen;
      logic [23:0] pend_addr;
      wens = 0; hss = 0; prev_wen = 1'b0; pend_addr = '0;
      resp_ready = 1'b1; cmd_we = 1'b1;
      for (int c = 0; c < 30; c++) begin
        if (o_gb_wen) begin
          wens++;
          chk("b2b_addr", 64'(o_gb_addr), 64'(pend_addr));
        end
        chk("b2b_no_consecutive_wen", 64'(prev_wen & o_gb_wen), 64'(0));
        chk("b2b_no_rstb", 64'(o_gb_rstb), 64'(0));
        if (o_resp_valid) hss++;
        prev_wen = o_gb_wen;
        cmd_valid = 1'b1; cmd_addr = 24'($urandom); cmd_wdata = $urandom;
        if (o_cmd_ready) pend_addr = cmd_addr;
        @(negedge clk);
      end
      cmd_valid = 1'b0; resp_ready = 1'b0;
      chk("b2b_wen_count", 64'(wens), 64'(10));
      chk("b2b_handshakes", 64'(hss), 64'(10));
      exp_txn[0] = exp_txn[0] + 16'(hss);
      chk("b2b_txn_count", 64'(o_txn_count), 64'(exp_txn[0]));
    end

    // Wrap of txn_count from 0xFFFF to 0x0000
    @(negedge clk);
    force u_a.txn_q = 16'hFFFF;
    @(negedge clk);
    release u_a.txn_q;
    @(negedge clk);
    chk("preload_txn", 64'(o_txn_count), 64'(16'hFFFF));
    exp_txn[0] = 16'hFFFF;
    do_txn(mk(1'b1, 24'h000020, 32'h77, 32'h0, 0, 8));
    chk("wrap_txn_zero", 64'(o_txn_count), 64'(0));

    // Reset pulse during RDWAIT aborts the read
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h000055;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_rstb", 64'(o_gb_rstb), 64'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort_rst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_txn[0] = 16'd0; exp_txn[1] = 16'd0;
    for (int c = 0; c < 12; c++) begin
      gb_rdata = $urandom;
      @(negedge clk);
      chk("abort_no_resp", 64'(o_resp_valid), 64'(0));
      chk("abort_no_rstb", 64'(o_gb_rstb), 64'(0));
      chk("abort_txn_zero", 64'(o_txn_count), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_host_master.md
GB_HOST_MASTER -- requirements
Module: gb_host_master

Interface
REQ-001 The block SHALL have parameter AW, default 24, ghostbus address width.
REQ-002 The block SHALL have parameter DW, default 32, ghostbus data width.
REQ-003 The block SHALL have parameter RD, default 8, read latency in cycles from gb_rstb to valid gb_rdata; legal range 1..255.
REQ-004 The block SHALL have port clk  input  1  the single clock, which also drives the ghostbus.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port cmd_valid  input  1  host request present.
REQ-007 The block SHALL have port cmd_ready  output  1  request accepted this cycle when cmd_valid is also high.
REQ-008 The block SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-009 The block SHALL have port cmd_addr  input  AW  target address.
REQ-010 The block SHALL have port cmd_wdata  input  DW  write data.
REQ-011 The block SHALL have port resp_valid  output  1  response present.
REQ-012 The block SHALL have port resp_ready  input  1  host consumes the response.
REQ-013 The block SHALL have port resp_we  output  1  echo of cmd_we for this response.
REQ-014 The block SHALL have port resp_rdata  output  DW  read data; 0 for writes.
REQ-015 The block SHALL have port gb_addr  output  AW  ghostbus address.
REQ-016 The block SHALL have port gb_wdata  output  DW  ghostbus write data.
REQ-017 The block SHALL have port gb_wen  output  1  one-cycle ghostbus write strobe.
REQ-018 The block SHALL have port gb_rstb  output  1  one-cycle ghostbus read strobe.
REQ-019 The block SHALL have port gb_rdata  input  DW  ghostbus read data.
REQ-020 The block SHALL have port txn_count  output  16  completed transactions, wrapping modulo 2^16.

Function
REQ-021 The FSM SHALL have states IDLE, STROBE, RDWAIT and RESP, with cmd_ready = (state==IDLE).
REQ-022 On accept (cmd_valid & cmd_ready at edge A), the block SHALL register cmd_addr, cmd_wdata and cmd_we, and enter STROBE.
REQ-023 In STROBE, the cycle after A, the block SHALL assert gb_wen if we=1, otherwise gb_rstb, for exactly one cycle.
REQ-024 gb_addr and gb_wdata SHALL change only on accept and SHALL remain stable until the next accept.
REQ-025 A write SHALL go STROBE -> RESP, with resp_rdata = 0 and resp_valid asserted in the cycle after the strobe cycle.
REQ-026 A read SHALL go STROBE -> RDWAIT, using an 8-bit down-counter loaded with RD-1 in STROBE and decremented each RDWAIT cycle.
REQ-027 A read SHALL capture gb_rdata into resp_rdata at the edge ending the cycle RD cycles after the strobe cycle, and then enter RESP.
REQ-028 For a read, resp_valid SHALL first be high RD+1 cycles after the strobe cycle.
REQ-029 For RD=1, RDWAIT SHALL last exactly one cycle.
REQ-030 In RESP, resp_valid, resp_we and resp_rdata SHALL be held stable until resp_ready is high at an edge.
REQ-031 On that resp_ready edge, the block SHALL return to IDLE and increment txn_count by 1, wrapping 0xFFFF -> 0x0000.
REQ-032 A new command SHALL NOT be accepted while a transaction is in flight or a response is pending, giving at most one outstanding transaction.
REQ-033 cmd_ready SHALL NOT combinationally depend on resp_ready; accept is at earliest the cycle after response handshake.
REQ-034 cmd_valid, cmd_we, cmd_addr and cmd_wdata SHALL be ignored outside IDLE.
REQ-035 gb_wen and gb_rstb SHALL never be asserted together, and never outside STROBE.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 rst_n low SHALL immediately and asynchronously force: state IDLE, cmd_ready 0 while rst_n low and 1 from the first edge after release, resp_valid 0, resp_we 0, resp_rdata 0, gb_addr 0, gb_wdata 0, gb_wen 0, gb_rstb 0, txn_count 0, counter 0.
REQ-038 Reset asserted mid-transaction (STROBE, RDWAIT or RESP) SHALL abort it: no strobe, no response and no count increment for that transaction after release.
REQ-039 Reset release SHALL be synchronised by the instantiator; the block SHALL take no action on the release edge other than leaving reset.

Verification
REQ-040 Write 0x42 to addr 0x000010 with resp_ready=1 -> gb_wen high 1 cycle at A+1 with gb_addr=0x000010 and gb_wdata=0x42; resp_valid at A+2, resp_we=1, resp_rdata=0; txn_count=1.
REQ-041 Read addr 0x000010 with RD=8 and gb_rdata driven 0xDEADBEEF only in cycle strobe+8 -> resp_rdata=0xDEADBEEF, resp_valid at strobe+9.
REQ-042 Read with resp_ready held low 20 cycles -> resp_valid, resp_we and resp_rdata stable all 20 cycles; cmd_ready=0 with cmd_valid high throughout; accept only after the handshake.
REQ-043 Back-to-back writes, cmd_valid held high -> one gb_wen per transaction, never in consecutive cycles, no overlap; txn_count increments per handshake.
REQ-044 Reset pulse during RDWAIT of a read -> all outputs 0 immediately; after release no resp_valid, and txn_count=0.
REQ-045 Preload txn_count 0xFFFF via 65535 transactions or force, then complete one more -> txn_count=0x0000; RD=1 read -> resp_valid at strobe+2.
